// File: rtl/disk_buf_pkg.sv
// Shared constants for the disk byte buffer: default geometry and the
// pointer/count width helpers used by disk_byte_buffer.
package disk_buf_pkg;

  localparam int DEPTH_DEF        = 16;
  localparam int SECTOR_BYTES_DEF = 512;

  // Width of a read/write pointer into a FIFO of the given depth.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy needs one more bit than a pointer so that "full" is representable.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  localparam int PTR_W = ptr_width(DEPTH_DEF);
  localparam int CNT_W = cnt_width(DEPTH_DEF);

endpackage

// File: rtl/disk_strobe_edge.sv
// Rising-edge detector for the disk-side level strobe. The previous-value
// register resets high so that a strobe already high through reset is not
// mistaken for a fresh byte.
module disk_strobe_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next value of the strobe history is simply the current strobe level.
  always_comb begin
    prev_d = strobe;
  end

  // Strobe history register; resets high to suppress a spurious edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= prev_d;
  end

  assign rise = strobe & ~prev_q;

endmodule

// File: rtl/disk_byte_buffer.sv
// Byte FIFO between the CPC disk data side and CtrlModule, with sticky
// overflow, sector-completion pulse and flush.
// Optional feature macro: DISK_BUF_STATS_EN adds a 16-bit saturating
// drop_count output.
module disk_byte_buffer
  import disk_buf_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int SECTOR_BYTES = SECTOR_BYTES_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_strobe,
  input  logic                        flush,
  input  logic                        ovf_clear,
  output logic [7:0]                  out_data,
  output logic                        out_valid,
  input  logic                        out_ack,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        overflow,
  output logic                        sector_done
`ifdef DISK_BUF_STATS_EN
  ,
  output logic [15:0]                 drop_count
`endif
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int SW = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] sec_cnt_q, sec_cnt_d;
  logic          overflow_q, overflow_d;
  logic          sector_done_q, sector_done_d;

  logic strobe_rise;
  logic wr_en;
  logic rd_en;
  logic drop;

  disk_strobe_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .strobe (in_strobe),
    .rise   (strobe_rise)
  );

  assign out_valid   = (count_q != '0);
  assign full        = (count_q == CW'(DEPTH));
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign sector_done = sector_done_q;
  // Gate the head byte so the port reads zero whenever the FIFO is empty.
  assign out_data    = out_valid ? mem_q[rd_ptr_q] : 8'h00;

  // Qualify push, pop and drop; flush overrides all traffic in its cycle.
  always_comb begin
    rd_en = out_ack && out_valid && !flush;
    wr_en = strobe_rise && (!full || (out_ack && out_valid)) && !flush;
    drop  = strobe_rise && full && !out_ack && !flush;
  end

  // Next-state for pointers, occupancy, sector counter and status flags.
  // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    sec_cnt_d     = sec_cnt_q;
    sector_done_d = 1'b0;
    overflow_d    = overflow_q;

    if (ovf_clear) overflow_d = 1'b0;
    if (drop)      overflow_d = 1'b1;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      sec_cnt_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (rd_en) begin
        if (sec_cnt_q == SW'(SECTOR_BYTES - 1)) begin
          sec_cnt_d     = '0;
          sector_done_d = 1'b1;
        end else begin
          sec_cnt_d = sec_cnt_q + SW'(1);
        end
      end
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      sec_cnt_q     <= '0;
      overflow_q    <= 1'b0;
      sector_done_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      sec_cnt_q     <= sec_cnt_d;
      overflow_q    <= overflow_d;
      sector_done_q <= sector_done_d;
    end
  end

  // Byte storage; written only on an accepted push.
  // NOTE: storage is deliberately not reset; occupancy decides validity, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef DISK_BUF_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped bytes; ovf_clear restarts it.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clear) drop_cnt_d = '0;
    if (drop && (drop_cnt_d != 16'hFFFF)) drop_cnt_d = drop_cnt_d + 16'd1;
  end

  // Drop statistics register.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_disk_byte_buffer.sv
// Directed self-checking bench for disk_byte_buffer (default 16-byte FIFO,
// 512-byte sectors).
module tb_disk_byte_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_strobe;
  logic       flush;
  logic       ovf_clear;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ack;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       sector_done;
`ifdef DISK_BUF_STATS_EN
  logic [15:0] drop_count;
`endif

  int total   = 0;
  int bad     = 0;
  int sd_seen = 0;

  always #5 clk = ~clk;

  disk_byte_buffer #(.DEPTH(16), .SECTOR_BYTES(512)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_strobe   (in_strobe),
    .flush       (flush),
    .ovf_clear   (ovf_clear),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .count       (count),
    .full        (full),
    .overflow    (overflow),
    .sector_done (sector_done)
`ifdef DISK_BUF_STATS_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
    if (sector_done === 1'b1) sd_seen++;
  endtask

  task automatic do_reset;
    rst = 1'b1; in_strobe = 1'b0; in_data = 8'h00;
    out_ack = 1'b0; flush = 1'b0; ovf_clear = 1'b0;
    tick; tick;
    rst = 1'b0;
    sd_seen = 0;
  endtask

  // One low-then-high strobe cycle offering byte b; the edge is seen in the second cycle.
  task automatic push(input logic [7:0] b);
    in_strobe = 1'b0; tick;
    in_data = b; in_strobe = 1'b1; tick;
  endtask

  // Push then pop n bytes one at a time; records the last pop index followed by sector_done.
  task automatic stream(input int n, output int last_done);
    logic [7:0] b;
    last_done = -1;
    for (int i = 0; i < n; i++) begin
      b = 8'(i);
      push(b);
      total++;
      if (out_data !== b || out_valid !== 1'b1) begin
        bad++; $display("FAIL stream_data[%0d] got=%h/%b exp=%h/1", i, out_data, out_valid, b);
      end
      out_ack = 1'b1; tick; out_ack = 1'b0;
      if (sector_done === 1'b1) last_done = i;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_strobe = 1'b1; in_data = 8'hA5;
    out_ack = 1'b0; flush = 1'b0; ovf_clear = 1'b0;
    tick; tick;
    total++;
    if (count !== 5'd0 || out_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 ||
        sector_done !== 1'b0 || out_data !== 8'h00) begin
      bad++; $display("FAIL reset_outputs got cnt=%0d v=%b f=%b o=%b sd=%b d=%h exp all zero",
                      count, out_valid, full, overflow, sector_done, out_data);
    end
    rst = 1'b0; tick; tick;
    total++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_strobe_high got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid);
    end
    in_strobe = 1'b0; tick;
    in_strobe = 1'b1; tick;
    total++;
    if (out_data !== 8'hA5 || out_valid !== 1'b1 || count !== 5'd1) begin
      bad++; $display("FAIL first_write got d=%h v=%b cnt=%0d exp d=a5 v=1 cnt=1", out_data, out_valid, count);
    end
  endtask

  task automatic test_ack_empty;
    do_reset;
    out_ack = 1'b1; tick; tick; tick; out_ack = 1'b0;
    total++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL ack_empty got cnt=%0d v=%b exp cnt=0 v=0", count, out_valid);
    end
    push(8'h5C);
    total++;
    if (count !== 5'd1 || out_data !== 8'h5C) begin
      bad++; $display("FAIL ack_empty_ptr got cnt=%0d d=%h exp cnt=1 d=5c", count, out_data);
    end
  endtask

  task automatic test_overflow;
    do_reset;
    for (int i = 0; i < 16; i++) push(8'(i));
    total++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      bad++; $display("FAIL fill16 got f=%b cnt=%0d o=%b exp f=1 cnt=16 o=0", full, count, overflow);
    end
    push(8'h10);
    total++;
    if (overflow !== 1'b1 || count !== 5'd16 || out_data !== 8'h00) begin
      bad++; $display("FAIL drop got o=%b cnt=%0d d=%h exp o=1 cnt=16 d=00", overflow, count, out_data);
    end
    ovf_clear = 1'b1; tick; ovf_clear = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_clear got o=%b exp o=0", overflow);
    end
    in_strobe = 1'b0; tick;
    in_data = 8'h11; in_strobe = 1'b1; ovf_clear = 1'b1; tick; ovf_clear = 1'b0;
    total++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      bad++; $display("FAIL clear_vs_drop got o=%b cnt=%0d exp o=1 cnt=16", overflow, count);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (out_data !== 8'(i)) begin
        bad++; $display("FAIL order[%0d] got=%h exp=%h", i, out_data, 8'(i));
      end
      out_ack = 1'b1; tick;
    end
    out_ack = 1'b0;
    total++;
    if (out_valid !== 1'b0 || count !== 5'd0) begin
      bad++; $display("FAIL drained got v=%b cnt=%0d exp v=0 cnt=0", out_valid, count);
    end
  endtask

  task automatic test_full_simultaneous;
    logic [7:0] exp_b;
    do_reset;
    for (int i = 0; i < 16; i++) push(8'(i + 8'h20));
    in_strobe = 1'b0; tick;
    in_data = 8'hAA; in_strobe = 1'b1; out_ack = 1'b1; tick; out_ack = 1'b0;
    total++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1 || out_data !== 8'h21) begin
      bad++; $display("FAIL full_rw got cnt=%0d o=%b f=%b d=%h exp cnt=16 o=0 f=1 d=21",
                      count, overflow, full, out_data);
    end
    for (int i = 1; i <= 16; i++) begin
      exp_b = (i == 16) ? 8'hAA : 8'(i + 8'h20);
      total++;
      if (out_data !== exp_b) begin
        bad++; $display("FAIL full_rw_order[%0d] got=%h exp=%h", i, out_data, exp_b);
      end
      out_ack = 1'b1; tick;
    end
    out_ack = 1'b0;
  endtask

  task automatic test_sector;
    int d;
    do_reset;
    stream(512, d);
    total++;
    if (d !== 511 || sd_seen !== 1) begin
      bad++; $display("FAIL sector_first got at=%0d pulses=%0d exp at=511 pulses=1", d, sd_seen);
    end
    tick;
    total++;
    if (sector_done !== 1'b0) begin
      bad++; $display("FAIL sector_pulse_width got sd=%b exp sd=0", sector_done);
    end
    stream(512, d);
    total++;
    if (d !== 511 || sd_seen !== 2) begin
      bad++; $display("FAIL sector_second got at=%0d pulses=%0d exp at=511 pulses=2", d, sd_seen);
    end
  endtask

  task automatic test_flush;
    int d;
    do_reset;
    for (int i = 0; i < 17; i++) push(8'(i));
    for (int i = 0; i < 11; i++) begin
      out_ack = 1'b1; tick;
    end
    out_ack = 1'b0;
    total++;
    if (count !== 5'd5 || overflow !== 1'b1) begin
      bad++; $display("FAIL pre_flush got cnt=%0d o=%b exp cnt=5 o=1", count, overflow);
    end
    in_strobe = 1'b0; tick;
    in_data = 8'h77; in_strobe = 1'b1; out_ack = 1'b1; flush = 1'b1; tick;
    out_ack = 1'b0; flush = 1'b0;
    total++;
    if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b1 || out_data !== 8'h00) begin
      bad++; $display("FAIL flush got cnt=%0d v=%b o=%b d=%h exp cnt=0 v=0 o=1 d=00",
                      count, out_valid, overflow, out_data);
    end
    ovf_clear = 1'b1; tick; ovf_clear = 1'b0;
    total++;
    if (overflow !== 1'b0) begin
      bad++; $display("FAIL flush_ovf_clear got o=%b exp o=0", overflow);
    end
    sd_seen = 0;
    stream(512, d);
    total++;
    if (d !== 511 || sd_seen !== 1) begin
      bad++; $display("FAIL flush_sector_reset got at=%0d pulses=%0d exp at=511 pulses=1", d, sd_seen);
    end
  endtask

  task automatic test_reset_traffic;
    do_reset;
    push(8'h01); push(8'h02); push(8'h03);
    out_ack = 1'b1; rst = 1'b1; tick;
    rst = 1'b0; out_ack = 1'b0;
    total++;
    if (count !== 5'd0 || out_valid !== 1'b0 || sector_done !== 1'b0) begin
      bad++; $display("FAIL reset_traffic got cnt=%0d v=%b sd=%b exp 0/0/0", count, out_valid, sector_done);
    end
    tick;
    total++;
    if (count !== 5'd0 || sector_done !== 1'b0) begin
      bad++; $display("FAIL post_reset got cnt=%0d sd=%b exp 0/0", count, sector_done);
    end
  endtask

`ifdef DISK_BUF_STATS_EN
  task automatic test_stats;
    do_reset;
    for (int i = 0; i < 16; i++) push(8'(i));
    push(8'hE0); push(8'hE1); push(8'hE2);
    total++;
    if (drop_count !== 16'd3) begin
      bad++; $display("FAIL drop_count got=%0d exp=3", drop_count);
    end
    ovf_clear = 1'b1; tick; ovf_clear = 1'b0;
    total++;
    if (drop_count !== 16'd0 || overflow !== 1'b0) begin
      bad++; $display("FAIL drop_count_clear got=%0d o=%b exp 0/0", drop_count, overflow);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_ack_empty;
    test_overflow;
    test_full_simultaneous;
    test_sector;
    test_flush;
    test_reset_traffic;
`ifdef DISK_BUF_STATS_EN
    test_stats;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disk_byte_buffer.md
DISK_BYTE_BUFFER -- requirements
Module: disk_byte_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, 4..64.
REQ-002 Parameter SECTOR_BYTES, default 512, popped-byte count per sector_done pulse; power of two.
REQ-003 clk  input  1  single clock (ck16 domain); every register SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  byte from the CPC disk side (disk_data_out).
REQ-006 in_strobe  input  1  level strobe (disk_data_clkout); each rising edge SHALL offer one byte.
REQ-007 flush  input  1  one-cycle pulse that empties the FIFO and zeroes the sector counter.
REQ-008 ovf_clear  input  1  one-cycle pulse that clears the sticky overflow flag.
REQ-009 out_data  output  8  head byte toward CtrlModule; valid only while out_valid=1.
REQ-010 out_valid  output  1  FIFO not empty.
REQ-011 out_ack  input  1  consumer pops the head byte when out_ack=1 and out_valid=1.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 full  output  1  count==DEPTH.
REQ-014 overflow  output  1  sticky lost-byte flag.
REQ-015 sector_done  output  1  one-cycle pulse on the pop that completes a sector.

Function
REQ-016 The block SHALL register in_strobe and detect a rising edge as in_strobe=1 and prev=0; it SHALL sample in_data in the same cycle.
REQ-017 A detected edge SHALL write in_data when full=0, or when full=1 and a pop happens in the same cycle.
REQ-018 An edge with full=1 and no pop SHALL drop the byte and set overflow on the next edge; FIFO contents SHALL stay unchanged.
REQ-019 Write latency: a byte written in cycle N SHALL show out_valid=1 and out_data equal to that byte in cycle N+1. There SHALL be no combinational bypass from in_data to out_data.
REQ-020 out_ack while out_valid=0 SHALL be ignored. It SHALL NOT change count or pointers.
REQ-021 A simultaneous write and pop SHALL leave count unchanged. Pointers SHALL wrap modulo DEPTH.
REQ-022 Data SHALL leave in strict FIFO order with no loss or duplication, apart from REQ-018 drops.
REQ-023 The sector counter SHALL increment on each pop. On the pop that brings it to SECTOR_BYTES it SHALL pulse sector_done in the following cycle and wrap to 0.
REQ-024 flush SHALL take priority over a write and a pop in the same cycle.
REQ-025 flush SHALL give count=0, out_valid=0 and sector counter=0 on the next cycle. It SHALL leave overflow untouched.
REQ-026 ovf_clear and a new overflow event in the same cycle SHALL leave overflow=1.

Reset
REQ-027 On rst, the block SHALL reset outputs to: out_valid=0, count=0, full=0, overflow=0, sector_done=0, out_data=8'h00.
REQ-028 On rst, the pointers and sector counter SHALL reset to 0.
REQ-029 On rst, the edge-detect register SHALL be set to 1, so that a strobe held high through reset produces no write.
REQ-030 rst during traffic SHALL discard all buffered bytes. No pulse SHALL be emitted in the cycle after reset.

Configuration
REQ-031 With DISK_BUF_STATS_EN defined, the block SHALL add output drop_count (16 bits).
REQ-032 drop_count SHALL increment, saturating, on each dropped byte. It SHALL clear on rst and on ovf_clear.
REQ-033 Without DISK_BUF_STATS_EN, the drop_count port and its logic SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-034 Package disk_buf_pkg SHALL hold: DEPTH and SECTOR_BYTES defaults, the pointer width constant, and the count width constant.
REQ-035 Sub-module disk_strobe_edge SHALL implement the REQ-016 / REQ-029 rising-edge detector. Everything else SHALL live in disk_byte_buffer.

Verification
REQ-036 Reset with in_strobe held high -> count stays 0 and out_valid stays 0; one high-low-high toggle of in_data=8'hA5 -> out_data=8'hA5 one cycle later.
REQ-037 17 edges with out_ack=0 (bytes 0x00..0x10) -> full=1 after 16, overflow=1, 0x10 dropped; pops return 0x00..0x0F in order.
REQ-038 Full FIFO, edge and out_ack in the same cycle -> count stays 16, no overflow, new byte appears last.
REQ-039 512 bytes streamed and popped -> exactly one sector_done pulse, one cycle after the 512th pop; byte 513 starts a new sector.
REQ-040 flush asserted with an edge and out_ack in the same cycle, 5 bytes held -> count=0 next cycle, overflow kept, ovf_clear then clears it.
REQ-041 With DISK_BUF_STATS_EN: 3 drops -> drop_count=3; ovf_clear -> 0.
